arc4_encrypt: RTL and testbench

// - Encryption-side PRGA engine: reads a length-prefixed plaintext message, XORs it with the ARC4

---
 rtl/arc4_encrypt.sv | 135 +++++++++++++
 tb/tb_arc4_encrypt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 PRGA encrypt engine: copies the plaintext length byte, then XORs each byte with the keystream from S.
// Latency 2 + 6*len cycles from en to rdy; en is ignored while busy, and memory reads are one cycle behind the address.
module arc4_encrypt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  typedef enum logic [3:0] {
    IDLE, RDLEN, WRLEN, READI, READJ, WRI, WRJ, READP, WRCT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic       s_we, ct_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_we      = 1'b0;
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          state_d = RDLEN;
        end
      end
      RDLEN: state_d = WRLEN;
      WRLEN: begin
        ct_wrdata = pt_rddata;
        ct_we     = 1'b1;
        len_d     = pt_rddata;
        if (pt_rddata == 8'd0) begin
          state_d = IDLE;
        end else begin
          i_d     = 8'd1;
          k_d     = 8'd1;
          state_d = READI;
        end
      end
      READI: begin
        s_addr  = i_q;
        state_d = READJ;
      end
      // j must be visible on the address bus this cycle so S[j] arrives in WRI.
      READJ: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_d;
        state_d = WRI;
      end
      WRI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_we     = 1'b1;
        state_d  = WRJ;
      end
      WRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_we     = 1'b1;
        state_d  = READP;
      end
      READP: begin
        s_addr  = si_q + sj_q;
        pt_addr = k_q;
        state_d = WRCT;
      end
      WRCT: begin
        ct_addr   = k_q;
        ct_wrdata = pt_rddata ^ s_rddata;
        ct_we     = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = k_q + 8'd1;
          state_d = READI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset suppresses writes in the cycle it is asserted, even if the state is still mid-message.
  assign s_wren  = s_we & rst_n;
  assign ct_wren = ct_we & rst_n;
  assign rdy     = (state_q == IDLE);

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural S/PT/CT memories plus a software RC4 reference model.
module tb_arc4_encrypt;
  logic       clk = 1'b0;
  logic       rst_n, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic       s_wren, ct_wren;

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  logic [7:0] s_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] exp_s [256];
  logic       load = 1'b0;
  int         ct_cnt [256];
  int         s_wr_cnt, both_cnt;
  int         n_chk = 0, n_pass = 0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]  <= s_init[a];
        ct_mem[a] <= 8'h5A;
      end
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end
  end

  always @(negedge clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) ct_cnt[a] <= 0;
      s_wr_cnt <= 0;
      both_cnt <= 0;
    end else begin
      if (ct_wren) ct_cnt[ct_addr] <= ct_cnt[ct_addr] + 1;
      if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
      if (s_wren && ct_wren) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_mems();
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic s_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic s_random();
    logic [7:0] t;
    int b;
    s_identity();
    for (int a = 255; a > 0; a--) begin
      b = $urandom_range(a, 0);
      t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
    end
  endtask

  task automatic s_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key[0] = k0; key[1] = k1; key[2] = k2;
    s_identity();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + s_init[i] + key[i % 3]) % 256;
      t = s_init[i]; s_init[i] = s_init[j]; s_init[j] = t;
    end
  endtask

  task automatic pt_random(input int len);
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'($urandom);
    pt_mem[0] = 8'(len);
  endtask

  // Textbook RC4 PRGA over a copy of S; byte 0 of the message is the length and passes through.
  task automatic model(input int len);
    int i, j, t;
    int S [256];
    for (int a = 0; a < 256; a++) S[a] = s_init[a];
    for (int a = 0; a < 256; a++) exp_ct[a] = 8'h5A;
    exp_ct[0] = pt_mem[0];
    i = 0; j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + S[i]) % 256;
      t = S[i]; S[i] = S[j]; S[j] = t;
      exp_ct[k] = pt_mem[k] ^ 8'(S[(S[i] + S[j]) % 256]);
    end
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(S[a]);
  endtask

  task automatic run(input bit spam, output int cyc);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 3000) begin
      en = (spam && cyc < 8) ? cyc[0] : 1'b0;
      cyc++;
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic verify(input string tag, input int len, input int cyc);
    int bad_cnt, bad_s, bad_ct;
    check({tag, "_rdy"}, rdy, 1);
    check({tag, "_cycles"}, cyc, 2 + 6 * len);
    bad_cnt = 0; bad_s = 0; bad_ct = 0;
    for (int a = 0; a < 256; a++) begin
      if (ct_cnt[a] != ((a <= len) ? 1 : 0)) bad_cnt++;
      if (s_mem[a] !== exp_s[a]) bad_s++;
      if (a > len && ct_mem[a] !== 8'h5A) bad_ct++;
    end
    for (int k = 0; k <= len && k < 8; k++) check({tag, "_ct"}, ct_mem[k], exp_ct[k]);
    for (int k = 8; k <= len; k++) if (ct_mem[k] !== exp_ct[k]) bad_ct++;
    check({tag, "_ct_tail_errs"}, bad_ct, 0);
    check({tag, "_ct_wren_per_addr_errs"}, bad_cnt, 0);
    check({tag, "_s_final_errs"}, bad_s, 0);
    check({tag, "_s_wren_count"}, s_wr_cnt, 2 * len);
    check({tag, "_wren_overlap"}, both_cnt, 0);
  endtask

  int cyc, len, snap;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    s_identity();
    pt_random(0);
    @(negedge clk);
    @(negedge clk);
    check("reset_rdy", rdy, 1);
    check("reset_s_wren", s_wren, 0);
    check("reset_ct_wren", ct_wren, 0);
    check("reset_addrs", {s_addr, pt_addr, ct_addr}, 0);
    rst_n = 1'b1;
    load_mems();
    repeat (10) @(negedge clk);
    check("idle_no_writes", s_wr_cnt + ct_cnt[0] + ct_cnt[1], 0);
    check("idle_rdy", rdy, 1);

    // Identity S, message 41 42 43
    s_identity();
    pt_random(3);
    pt_mem[1] = 8'h41; pt_mem[2] = 8'h42; pt_mem[3] = 8'h43;
    load_mems();
    model(3);
    run(1'b0, cyc);
    verify("ident3", 3, cyc);
    check("ident3_ct1", ct_mem[1], 8'h43);
    check("ident3_ct2", ct_mem[2], 8'h47);
    check("ident3_ct3", ct_mem[3], 8'h44);
    check("ident3_s235", {s_mem[2], s_mem[3], s_mem[5]}, 24'h030502);

    // Empty message
    s_random();
    pt_random(0);
    load_mems();
    model(0);
    run(1'b0, cyc);
    verify("len0", 0, cyc);

    // Full-length message with a real key schedule
    s_ksa(8'h00, 8'h00, 8'h01);
    pt_random(255);
    load_mems();
    model(255);
    run(1'b0, cyc);
    verify("len255", 255, cyc);

    // en toggled while busy must not disturb the run
    s_identity();
    pt_random(3);
    load_mems();
    model(3);
    run(1'b1, cyc);
    verify("spam_en", 3, cyc);

    // Reset during WRJ of byte 2 (busy cycle 12)
    s_identity();
    pt_random(3);
    load_mems();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (11) @(negedge clk);
    check("wrj2_s_wren", s_wren, 1);
    check("wrj2_s_addr", s_addr, 8'h03);
    rst_n = 1'b0;
    #1;
    check("rst_mid_s_wren", s_wren, 0);
    check("rst_mid_ct_wren", ct_wren, 0);
    snap = s_wr_cnt + ct_cnt[0] + ct_cnt[1] + ct_cnt[2] + ct_cnt[3];
    @(negedge clk);
    check("rst_mid_rdy", rdy, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_more_writes", s_wr_cnt + ct_cnt[0] + ct_cnt[1] + ct_cnt[2] + ct_cnt[3], snap);
    s_identity();
    pt_random(3);
    load_mems();
    model(3);
    run(1'b0, cyc);
    verify("restart", 3, cyc);

    // Random S permutations and lengths
    for (int r = 0; r < 6; r++) begin
      len = (r == 0) ? 1 : $urandom_range(40, 1);
      s_random();
      pt_random(len);
      load_mems();
      model(len);
      run(1'b0, cyc);
      verify("rand", len, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
